// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: byte stream between the UART receiver, the FIFO and the debug unit.
// master = receiver/debug side, slave = FIFO.
interface uart_rx_fifo_if #(
  parameter int unsigned N_DATA = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              wr;
  logic [N_DATA-1:0] wr_data;
  logic              rd;
  logic              flush;
  logic              clr_ovf;
  logic [N_DATA-1:0] din;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;

  modport master (
    output wr, wr_data, rd, flush, clr_ovf,
    input  din, empty, full, count, overflow
  );

  modport slave (
    input  wr, wr_data, rd, flush, clr_ovf,
    output din, empty, full, count, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 2^ADDR_W x N_DATA byte FIFO from the UART receiver to the debug unit.
// Sticky overflow on a dropped write. Optional macro RX_FIFO_FWFT_EN selects
// first-word fall-through output; default is a registered read (din valid the
// cycle after the accepted pop).
module uart_rx_fifo #(
  parameter int unsigned N_DATA = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic            clock,
  input  logic            reset,
  uart_rx_fifo_if.slave   bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [N_DATA-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wp_q, wp_d;
  logic [ADDR_W-1:0] rp_q, rp_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              empty_c, full_c, rd_acc_c, wr_acc_c;

  // Flags come from the registered occupancy; a pop may free the slot a write needs.
  assign empty_c  = (count_q == '0);
  assign full_c   = (count_q == CNT_W'(DEPTH));
  assign rd_acc_c = bus.rd & ~empty_c;
  assign wr_acc_c = bus.wr & (~full_c | rd_acc_c);

  // Next-state for pointers, occupancy and sticky overflow; flush overrides traffic.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (bus.flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (wr_acc_c) wp_d = wp_q + ADDR_W'(1);
      if (rd_acc_c) rp_d = rp_q + ADDR_W'(1);
      if (wr_acc_c && !rd_acc_c)      count_d = count_q + CNT_W'(1);
      else if (rd_acc_c && !wr_acc_c) count_d = count_q - CNT_W'(1);
    end
    if (bus.clr_ovf) ovf_d = 1'b0;
    if (!bus.flush && bus.wr && !wr_acc_c) ovf_d = 1'b1;
  end

  // Control state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage array; contents need no reset since pointers gate visibility.
  always_ff @(posedge clock) begin
    if (!bus.flush && wr_acc_c) mem_q[wp_q] <= bus.wr_data;
  end

`ifdef RX_FIFO_FWFT_EN
  // Head byte falls through whenever something is stored.
  assign bus.din = empty_c ? '0 : mem_q[rp_q];
`else
  logic [N_DATA-1:0] din_q, din_d;

  // Popped byte is captured on the accepting edge and held until the next pop.
  always_comb begin
    din_d = din_q;
    if (!bus.flush && rd_acc_c) din_d = mem_q[rp_q];
  end

  // Registered read data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) din_q <= '0;
    else       din_q <= din_d;
  end

  assign bus.din = din_q;
`endif

  assign bus.empty    = empty_c;
  assign bus.full     = full_c;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo (either din build).
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  uart_rx_fifo_if #(.N_DATA(8), .ADDR_W(4)) bus ();

  uart_rx_fifo #(.N_DATA(8), .ADDR_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock with the given strobes; pop data is checked before the edge in
  // fall-through builds and after it in registered builds.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                     input logic chk, input logic [7:0] exp);
`ifdef RX_FIFO_FWFT_EN
    if (chk) check("din_pop", 32'(bus.din), 32'(exp));
`endif
    bus.wr = w; bus.wr_data = d; bus.rd = r;
    @(posedge clock); #1;
    bus.wr = 1'b0; bus.wr_data = 8'h00; bus.rd = 1'b0;
`ifndef RX_FIFO_FWFT_EN
    if (chk) check("din_pop", 32'(bus.din), 32'(exp));
`endif
  endtask

  task automatic wr1(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic pop(input logic [7:0] exp);
    cyc(1'b0, 8'h00, 1'b1, 1'b1, exp);
  endtask

  initial begin
    logic [7:0] v1 [4];
    logic [7:0] exp_idle;
    n_checks = 0;
    n_errors = 0;
    bus.wr = 1'b0; bus.wr_data = 8'h00; bus.rd = 1'b0;
    bus.flush = 1'b0; bus.clr_ovf = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_din",   32'(bus.din), 32'h0);
    check("rst_empty", 32'(bus.empty), 32'h1);
    check("rst_full",  32'(bus.full), 32'h0);
    check("rst_count", 32'(bus.count), 32'h0);
    check("rst_ovf",   32'(bus.overflow), 32'h0);

    // Four writes then four pops
    v1[0] = 8'h00; v1[1] = 8'h00; v1[2] = 8'h23; v1[3] = 8'h80;
    for (int i = 0; i < 4; i++) begin
      wr1(v1[i]);
      check("seq_wr_count", 32'(bus.count), 32'(i + 1));
      check("seq_wr_empty", 32'(bus.empty), 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      pop(v1[i]);
      check("seq_rd_count", 32'(bus.count), 32'(3 - i));
    end
    check("seq_empty", 32'(bus.empty), 32'h1);

    // Fill to 16, overflow on 17th, drain, clear overflow
    for (int i = 1; i <= 16; i++) wr1(8'(i));
    check("fill_full",  32'(bus.full), 32'h1);
    check("fill_count", 32'(bus.count), 32'd16);
    check("fill_ovf0",  32'(bus.overflow), 32'h0);
    wr1(8'hFF);
    check("ovf_set",   32'(bus.overflow), 32'h1);
    check("ovf_count", 32'(bus.count), 32'd16);
    for (int i = 1; i <= 16; i++) pop(8'(i));
    check("drain_empty", 32'(bus.empty), 32'h1);
    check("drain_ovf",   32'(bus.overflow), 32'h1);
    bus.clr_ovf = 1'b1;
    @(posedge clock); #1;
    bus.clr_ovf = 1'b0;
    check("clr_ovf", 32'(bus.overflow), 32'h0);

    // Full with simultaneous write and read
    for (int i = 0; i < 16; i++) wr1(8'h30 + 8'(i));
    cyc(1'b1, 8'hAA, 1'b1, 1'b1, 8'h30);
    check("full_rw_count", 32'(bus.count), 32'd16);
    check("full_rw_ovf",   32'(bus.overflow), 32'h0);
    for (int i = 1; i < 16; i++) pop(8'h30 + 8'(i));
    pop(8'hAA);
    check("full_rw_empty", 32'(bus.empty), 32'h1);

    // Reads on empty are ignored
`ifdef RX_FIFO_FWFT_EN
    exp_idle = 8'h00;
`else
    exp_idle = 8'hAA;
`endif
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
      check("erd_din",   32'(bus.din), 32'(exp_idle));
      check("erd_count", 32'(bus.count), 32'h0);
      check("erd_ovf",   32'(bus.overflow), 32'h0);
    end
    cyc(1'b1, 8'h5C, 1'b1, 1'b0, 8'h00);
    check("erw_count", 32'(bus.count), 32'h1);
    check("erw_empty", 32'(bus.empty), 32'h0);
`ifndef RX_FIFO_FWFT_EN
    check("erw_din", 32'(bus.din), 32'hAA);
`endif
    pop(8'h5C);
    check("erw_drained", 32'(bus.count), 32'h0);

    // Wrap-around: write every cycle, pop lagging by two
    for (int i = 0; i < 40; i++) begin
      if (i < 2) wr1(8'h40 + 8'(i));
      else       cyc(1'b1, 8'h40 + 8'(i), 1'b1, 1'b1, 8'h40 + 8'(i - 2));
      if (bus.count > 5'd3) check("wrap_count_le3", 32'(bus.count), 32'd3);
    end
    check("wrap_count", 32'(bus.count), 32'd2);
    pop(8'h40 + 8'd38);
    pop(8'h40 + 8'd39);
    check("wrap_empty", 32'(bus.empty), 32'h1);

    // Asynchronous reset mid-transfer
    for (int i = 0; i < 5; i++) wr1(8'h90 + 8'(i));
    check("pre_rst_count", 32'(bus.count), 32'd5);
    #3 reset = 1'b1;
    #1;
    check("arst_count", 32'(bus.count), 32'h0);
    check("arst_empty", 32'(bus.empty), 32'h1);
    check("arst_din",   32'(bus.din), 32'h0);
    #2 reset = 1'b0;
    @(posedge clock); #1;
    wr1(8'h11);
    wr1(8'h12);
    pop(8'h11);
    pop(8'h12);

    // Overflow set beats a simultaneous clear
    for (int i = 0; i < 16; i++) wr1(8'hC0 + 8'(i));
    bus.clr_ovf = 1'b1;
    wr1(8'hEE);
    bus.clr_ovf = 1'b0;
    check("ovf_set_wins", 32'(bus.overflow), 32'h1);

    // Flush clears contents, keeps overflow, drops same-cycle traffic
    bus.flush = 1'b1;
    cyc(1'b1, 8'h66, 1'b1, 1'b0, 8'h00);
    bus.flush = 1'b0;
    check("flush_count", 32'(bus.count), 32'h0);
    check("flush_empty", 32'(bus.empty), 32'h1);
    check("flush_full",  32'(bus.full), 32'h0);
    check("flush_ovf",   32'(bus.overflow), 32'h1);
`ifdef RX_FIFO_FWFT_EN
    check("flush_din", 32'(bus.din), 32'h0);
`endif
    wr1(8'h7E);
    check("post_flush_empty", 32'(bus.empty), 32'h0);
    check("post_flush_count", 32'(bus.count), 32'h1);
`ifdef RX_FIFO_FWFT_EN
    check("fwft_din", 32'(bus.din), 32'h7E);
`endif
    pop(8'h7E);
    check("final_empty", 32'(bus.empty), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Byte FIFO between the UART receiver and the debug unit of the MIPS pipeline top. It captures every byte the receiver completes (`rx_done` tick) and presents it to the debug unit on `din`/`empty`. The debug unit pops bytes with a one-cycle read strobe while it assembles instruction words and mode commands. Overflow is flagged sticky so a host-side protocol error is visible in debug.

## Interface
- `N_DATA`, 8 — byte width.
- `ADDR_W`, 4 — log2 of depth; depth = 2^ADDR_W = 16 entries.
- `clock`  in  1  — system clock, 50 MHz.
- `reset`  in  1  — asynchronous, active-high; clears all state.
- `wr`  in  1  — write strobe, one-cycle `rx_done` tick from the UART receiver.
- `wr_data`  in  N_DATA  — received byte, valid with `wr`.
- `rd`  in  1  — read/pop strobe from the debug unit; level is sampled each cycle.
- `flush`  in  1  — synchronous clear of contents; `overflow` is left intact.
- `clr_ovf`  in  1  — synchronous clear of `overflow`.
- `din`  out  N_DATA  — byte to the debug unit.
- `empty`  out  1  — 1 = no stored byte.
- `full`  out  1  — 1 = 2^ADDR_W bytes stored.
- `count`  out  ADDR_W+1  — occupancy, 0..2^ADDR_W.
- `overflow`  out  1  — sticky; set when a write is dropped.

## Operation
- Storage is a 2^ADDR_W × N_DATA register array with write pointer `wp`, read pointer `rp` (ADDR_W bits, natural wrap 15→0) and a separate occupancy counter `count`.
- Write accept: `wr & (~full | rd_acc)`. The byte is stored at `wp`, then `wp` increments.
- Read accept (`rd_acc`): `rd & ~empty`. `rp` increments. A read on empty is ignored: pointers, count and `din` are unchanged, and no flag is raised.
- Count update:
  - +1 on write only.
  - −1 on read only.
  - Unchanged on simultaneous accepted read and write.
- Full with simultaneous `rd` and `wr`: both accepted, count stays 16, no overflow.
- Empty with simultaneous `rd` and `wr`: write accepted, read ignored, count becomes 1.
- Dropped write (`wr & full & ~rd`): data discarded, `overflow` ← 1 next edge.
- `flush` has priority over `wr`/`rd` in the same cycle: `wp`=`rp`=0 and count=0; the bytes arriving that cycle are dropped without setting overflow.
- `clr_ovf` and a simultaneous overflow event: set wins.
- `empty` = (count==0) and `full` = (count==2^ADDR_W), both taken from the registered count.
- No state machine. Behaviour is fully described by the pointers and count.

## Timing
- Reset values: `din`=0, `empty`=1, `full`=0, `count`=0, `overflow`=0, `wp`=`rp`=0. Array contents are don't-care.
- Reset asserted mid-transfer clears everything immediately, without waiting for a clock. The first write after reset release lands at entry 0.
- Write to an empty FIFO at edge N: `empty` falls and `count`=1 after edge N, i.e. 1-cycle write-to-visible latency.
- Default (registered read):
  - `din` is loaded from `mem[rp]` on the edge that accepts `rd`, so the popped byte is valid from the following cycle.
  - `din` holds its value until the next accepted read.
  - Read latency is 1 cycle.
- Back-to-back `rd` every cycle drains one byte per cycle. The last pop makes `empty`=1 after the same edge.
- Sustained throughput: 1 write + 1 read per cycle.

## Configuration
- `RX_FIFO_FWFT_EN` defined (first-word fall-through):
  - `din` = `mem[rp]` combinationally whenever `empty`=0, so the head byte is visible in the same cycle `empty` falls.
  - `rd` acknowledges and discards the head byte.
  - `din`=0 while empty.
- `RX_FIFO_FWFT_EN` undefined: the registered-read behaviour above, which the current debug unit (pop, then sample next cycle) uses.
- Flags, count and overflow behave identically in both builds.

## Test plan
- Reset, then write 0x00, 0x00, 0x23, 0x80 on consecutive cycles, then `rd` ×4:
  - `count` goes 1,2,3,4 after each write, then 3,2,1,0.
  - `din` = 0x00, 0x00, 0x23, 0x80 one cycle after each pop.
  - `empty`=1 after the fourth pop.
- Write 16 bytes 0x01..0x10, then a 17th byte 0xFF:
  - `full`=1 and `overflow`=1; `count`=16.
  - Draining returns 0x01..0x10 and never 0xFF.
  - Pulsing `clr_ovf` drops `overflow` to 0.
- Full FIFO, then simultaneous `wr`(0xAA) + `rd`:
  - `count` stays 16 and `overflow` stays 0.
  - After 15 further pops, the 16th pop returns 0xAA.
- Empty FIFO, then `rd` alone for 3 cycles:
  - `din`, `count` and pointers are unchanged; no overflow.
  - Then simultaneous `wr`(0x5C) + `rd` gives `count`=1, `empty`=0.
- Wrap-around: 40 writes of an incrementing value interleaved with pops, keeping `count` ≤ 3 → every popped byte equals the expected sequence across pointer wraps 15→0.
- Reset asserted asynchronously with 5 bytes stored, then `flush` tested separately:
  - Reset gives `empty`=1, `count`=0 before the next edge.
  - `flush` with `overflow`=1 leaves `overflow`=1.
  - With `RX_FIFO_FWFT_EN`, a write of 0x7E shows `din`=0x7E in the same cycle `empty` falls.
